guess_tracker: RTL and testbench

//  Hangman game-state stage between letter selection and the text generator.

---
 rtl/guess_tracker_if.sv | 33 +++
 rtl/guess_tracker.sv | 172 +++++++++++++++++
 tb/tb_guess_tracker.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/guess_tracker_if.sv
// Bus between letter selection / text generator and the guess tracker.
interface guess_tracker_if #(
    parameter int unsigned WORD_LEN = 7,
    parameter int unsigned CHAR_W   = 7
);
    logic                         restart;
    logic                         guess_valid;
    logic [CHAR_W-1:0]            guess_letter;
    logic [WORD_LEN*CHAR_W-1:0]   word_in;
    logic [WORD_LEN*CHAR_W-1:0]   out_word;
    logic [WORD_LEN-1:0]          revealed;
    logic [3:0]                   wrong_count;
    logic                         busy;
    logic                         win;
    logic                         lose;
    logic                         done_pulse;
    logic                         dup_pulse;
    logic                         invalid_pulse;

    // Driver side: game control and guesses.
    modport master (
        output restart, guess_valid, guess_letter, word_in,
        input  out_word, revealed, wrong_count, busy, win, lose,
               done_pulse, dup_pulse, invalid_pulse
    );

    // Tracker side.
    modport slave (
        input  restart, guess_valid, guess_letter, word_in,
        output out_word, revealed, wrong_count, busy, win, lose,
               done_pulse, dup_pulse, invalid_pulse
    );
endinterface

// File: rtl/guess_tracker.sv
// Hangman game state: latches the word, scans one position per cycle for each
// accepted guess, and drives the masked word, wrong-guess count and win/lose.
module guess_tracker #(
    parameter int unsigned       WORD_LEN  = 7,
    parameter int unsigned       CHAR_W    = 7,
    parameter int unsigned       MAX_WRONG = 6,
    parameter logic [CHAR_W-1:0] BLANK     = 7'h5F
) (
    input  logic           clk,
    input  logic           reset,
    guess_tracker_if.slave bus
);

    localparam int unsigned       IdxW      = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;
    localparam logic [CHAR_W-1:0] CharA     = CHAR_W'(7'h41);
    localparam logic [CHAR_W-1:0] CharZ     = CHAR_W'(7'h5A);
    localparam logic [CHAR_W-1:0] CharSpace = CHAR_W'(7'h20);
    localparam logic [3:0]        MaxWrong  = 4'(MAX_WRONG);
    localparam logic [IdxW-1:0]   LastIdx   = IdxW'(WORD_LEN - 1);

    typedef enum logic [2:0] {StIdle, StPlay, StCheck, StResolve, StWin, StLose} state_e;

    state_e                     state_q, state_d;
    logic [WORD_LEN*CHAR_W-1:0] word_q, word_d;
    logic [WORD_LEN*CHAR_W-1:0] out_word_q, out_word_d;
    logic [WORD_LEN-1:0]        revealed_q, revealed_d;
    logic [3:0]                 wrong_q, wrong_d;
    logic [25:0]                used_q, used_d;
    logic [CHAR_W-1:0]          letter_q, letter_d;
    logic                       hit_q, hit_d;
    logic [IdxW-1:0]            idx_q, idx_d;
    logic                       done_q, done_d;
    logic                       dup_q, dup_d;
    logic                       invalid_q, invalid_d;

    logic [CHAR_W-1:0] cur_char;
    logic [CHAR_W-1:0] letter_off;
    logic              letter_ok;

    assign letter_ok  = (bus.guess_letter >= CharA) && (bus.guess_letter <= CharZ);
    assign letter_off = bus.guess_letter - CharA;

    // Select the word character under the scan index.
    always_comb begin
        cur_char = '0;
        for (int i = 0; i < WORD_LEN; i++) begin
            if (idx_q == IdxW'(i)) cur_char = word_q[i*CHAR_W +: CHAR_W];
        end
    end

    // Next-state: restart overrides everything, then per-state game rules.
    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        revealed_d = revealed_q;
        wrong_d    = wrong_q;
        used_d     = used_q;
        letter_d   = letter_q;
        hit_d      = hit_q;
        idx_d      = idx_q;
        done_d     = 1'b0;
        dup_d      = 1'b0;
        invalid_d  = 1'b0;

        if (bus.restart) begin
            word_d  = bus.word_in;
            used_d  = '0;
            wrong_d = '0;
            hit_d   = 1'b0;
            idx_d   = '0;
            state_d = StPlay;
            // Spaces pad short words and are shown from the start.
            for (int i = 0; i < WORD_LEN; i++) begin
                revealed_d[i] = (bus.word_in[i*CHAR_W +: CHAR_W] == CharSpace);
            end
        end else begin
            unique case (state_q)
                StPlay: begin
                    if (bus.guess_valid) begin
                        if (!letter_ok) begin
                            invalid_d = 1'b1;
                        end else if (used_q[letter_off[4:0]]) begin
                            dup_d = 1'b1;
                        end else begin
                            used_d[letter_off[4:0]] = 1'b1;
                            letter_d = bus.guess_letter;
                            hit_d    = 1'b0;
                            idx_d    = '0;
                            state_d  = StCheck;
                        end
                    end
                end
                StCheck: begin
                    if (cur_char == letter_q) begin
                        hit_d = 1'b1;
                        for (int i = 0; i < WORD_LEN; i++) begin
                            if (idx_q == IdxW'(i)) revealed_d[i] = 1'b1;
                        end
                    end
                    if (idx_q == LastIdx) begin
                        state_d = StResolve;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                StResolve: begin
                    done_d = 1'b1;
                    if (!hit_q && (wrong_q != MaxWrong)) wrong_d = wrong_q + 4'd1;
                    if (&revealed_q) begin
                        state_d = StWin;
                    end else if (wrong_d == MaxWrong) begin
                        state_d = StLose;
                    end else begin
                        state_d = StPlay;
                    end
                end
                StIdle, StWin, StLose: ;
                default: state_d = StIdle;
            endcase
        end
    end

    // Masked word follows the next revealed mask so it lands with it.
    always_comb begin
        out_word_d = '0;
        for (int i = 0; i < WORD_LEN; i++) begin
            out_word_d[i*CHAR_W +: CHAR_W] = revealed_d[i] ? word_d[i*CHAR_W +: CHAR_W] : BLANK;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            word_q     <= '0;
            out_word_q <= {WORD_LEN{BLANK}};
            revealed_q <= '0;
            wrong_q    <= '0;
            used_q     <= '0;
            letter_q   <= '0;
            hit_q      <= 1'b0;
            idx_q      <= '0;
            done_q     <= 1'b0;
            dup_q      <= 1'b0;
            invalid_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            out_word_q <= out_word_d;
            revealed_q <= revealed_d;
            wrong_q    <= wrong_d;
            used_q     <= used_d;
            letter_q   <= letter_d;
            hit_q      <= hit_d;
            idx_q      <= idx_d;
            done_q     <= done_d;
            dup_q      <= dup_d;
            invalid_q  <= invalid_d;
        end
    end

    assign bus.out_word      = out_word_q;
    assign bus.revealed      = revealed_q;
    assign bus.wrong_count   = wrong_q;
    assign bus.busy          = (state_q == StCheck) || (state_q == StResolve);
    assign bus.win           = (state_q == StWin);
    assign bus.lose          = (state_q == StLose);
    assign bus.done_pulse    = done_q;
    assign bus.dup_pulse     = dup_q;
    assign bus.invalid_pulse = invalid_q;

endmodule

// File: tb/tb_guess_tracker.sv
// Scoreboard bench for guess_tracker: a word/letter-set game model predicts
// every pulse and the outputs seen with it; a monitor pops and compares.
module tb_guess_tracker;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    guess_tracker_if #(.WORD_LEN(7), .CHAR_W(7)) gif ();

    guess_tracker dut (
        .clk   (clk),
        .reset (reset),
        .bus   (gif)
    );

    // kind: 0 done, 1 dup, 2 invalid
    typedef struct {
        int          kind;
        int          cyc;
        logic [48:0] ow;
        logic [3:0]  wc;
        logic        win;
        logic        lose;
    } exp_t;

    exp_t sb[$];

    // Game model: phase 0 idle, 1 play, 2 won, 3 lost.
    logic [6:0] m_word[7];
    bit         m_used[26];
    int         m_wrong;
    int         phase;

    function automatic logic [48:0] pack(input string s);
        logic [48:0] p;
        byte         b;
        for (int i = 0; i < 7; i++) begin
            b = (i < s.len()) ? s[i] : 8'h20;
            p[i*7 +: 7] = b[6:0];
        end
        return p;
    endfunction

    function automatic bit shown(input int i);
        if (m_word[i] == 7'h20) return 1'b1;
        return m_used[int'(m_word[i]) - 65];
    endfunction

    function automatic logic [48:0] m_out_word();
        logic [48:0] p;
        for (int i = 0; i < 7; i++) p[i*7 +: 7] = shown(i) ? m_word[i] : 7'h5F;
        return p;
    endfunction

    function automatic int model_apply(input logic [6:0] c);
        bit in_word;
        bit all;
        if (phase != 1) return -1;
        if (c < 7'h41 || c > 7'h5A) return 2;
        if (m_used[int'(c) - 65]) return 1;
        m_used[int'(c) - 65] = 1'b1;
        in_word = 1'b0;
        all = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (m_word[i] == c) in_word = 1'b1;
            if (!shown(i)) all = 1'b0;
        end
        if (!in_word) m_wrong = (m_wrong >= 6) ? 6 : m_wrong + 1;
        if (all) phase = 2;
        else if (m_wrong == 6) phase = 3;
        return 0;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_restart(input logic [48:0] w);
        @(negedge clk);
        gif.restart = 1'b1;
        gif.word_in = w;
        for (int i = 0; i < 7; i++) m_word[i] = w[i*7 +: 7];
        for (int i = 0; i < 26; i++) m_used[i] = 1'b0;
        m_wrong = 0;
        phase = 1;
        @(negedge clk);
        gif.restart = 1'b0;
    endtask

    task automatic do_guess(input logic [6:0] c, input bit poke);
        exp_t e;
        int   kind;
        @(negedge clk);
        gif.guess_valid  = 1'b1;
        gif.guess_letter = c;
        kind = model_apply(c);
        if (kind >= 0) begin
            e.kind = kind;
            e.cyc  = cyc + 1 + ((kind == 0) ? 8 : 0);
            e.ow   = m_out_word();
            e.wc   = 4'(m_wrong);
            e.win  = (phase == 2);
            e.lose = (phase == 3);
            sb.push_back(e);
        end
        @(negedge clk);
        gif.guess_valid = 1'b0;
        if (kind == 0) begin
            repeat (2) @(negedge clk);
            if (poke) begin
                // Arrives mid-scan; must be dropped without trace.
                gif.guess_valid  = 1'b1;
                gif.guess_letter = 7'(7'h41 + $urandom_range(0, 25));
                @(negedge clk);
                gif.guess_valid = 1'b0;
            end
            repeat (8) @(negedge clk);
        end else begin
            @(negedge clk);
        end
    endtask

    // Monitor: every pulse must match the head of the scoreboard.
    int   act_kind;
    exp_t me;
    always @(negedge clk) begin
        if (!reset && (gif.done_pulse || gif.dup_pulse || gif.invalid_pulse)) begin
            act_kind = gif.done_pulse ? 0 : (gif.dup_pulse ? 1 : 2);
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: got kind=%0d at cycle %0d, expected no pulse",
                         act_kind, cyc);
            end else begin
                me = sb.pop_front();
                if (act_kind != me.kind || cyc != me.cyc || gif.out_word !== me.ow ||
                    gif.wrong_count !== me.wc || gif.win !== me.win || gif.lose !== me.lose ||
                    (int'(gif.done_pulse) + int'(gif.dup_pulse) + int'(gif.invalid_pulse)) != 1) begin
                    errors++;
                    $display("FAIL event: got kind=%0d cyc=%0d word=%h wrong=%0d win=%b lose=%b, expected kind=%0d cyc=%0d word=%h wrong=%0d win=%b lose=%b",
                             act_kind, cyc, gif.out_word, gif.wrong_count, gif.win, gif.lose,
                             me.kind, me.cyc, me.ow, me.wc, me.win, me.lose);
                end
            end
        end
    end

    logic [48:0] hangman;
    logic [48:0] rw;
    logic [6:0]  c;
    int          len;
    int          r;

    initial begin
        gif.restart      = 1'b0;
        gif.guess_valid  = 1'b0;
        gif.guess_letter = '0;
        gif.word_in      = '0;
        phase   = 0;
        m_wrong = 0;
        hangman = pack("HANGMAN");

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_out_word", gif.out_word, pack("_______"));
        check("rst_revealed", gif.revealed, 7'h00);
        check("rst_wrong", gif.wrong_count, 4'd0);
        check("rst_flags", {gif.busy, gif.win, gif.lose, gif.done_pulse, gif.dup_pulse,
                            gif.invalid_pulse}, 6'b0);
        reset = 1'b0;

        // IDLE ignores guesses
        do_guess(7'h41, 1'b0);

        do_restart(hangman);
        check("restart_word", gif.out_word, pack("_______"));
        check("restart_wrong", gif.wrong_count, 4'd0);
        check("restart_busy", gif.busy, 1'b0);

        do_guess("A", 1'b0);
        check("guess_A_word", gif.out_word, pack("_A___A_"));
        do_guess("Z", 1'b0);
        do_guess("Z", 1'b0);
        do_guess(7'h31, 1'b0);
        check("dup_invalid_wrong", gif.wrong_count, 4'd1);
        do_guess("H", 1'b0);
        do_guess("N", 1'b0);
        do_guess("G", 1'b0);
        do_guess("M", 1'b0);
        check("win_flag", gif.win, 1'b1);
        check("win_word", gif.out_word, hangman);
        do_guess("Q", 1'b0);
        check("win_hold", {gif.win, gif.wrong_count}, {1'b1, 4'd1});

        // Six misses, with mid-scan pokes
        do_restart(hangman);
        do_guess("B", 1'b1);
        do_guess("C", 1'b1);
        do_guess("D", 1'b0);
        do_guess("E", 1'b1);
        do_guess("F", 1'b0);
        do_guess("I", 1'b1);
        check("lose_flag", gif.lose, 1'b1);
        check("lose_wrong", gif.wrong_count, 4'd6);
        do_guess("A", 1'b0);

        // Restart together with a guess, mid-scan
        do_restart(hangman);
        do_guess("Z", 1'b0);
        @(negedge clk);
        gif.guess_valid  = 1'b1;
        gif.guess_letter = "A";
        @(negedge clk);
        gif.guess_valid = 1'b0;
        repeat (2) @(negedge clk);
        gif.restart      = 1'b1;
        gif.guess_valid  = 1'b1;
        gif.guess_letter = "H";
        gif.word_in      = pack("CAT");
        for (int i = 0; i < 7; i++) m_word[i] = gif.word_in[i*7 +: 7];
        for (int i = 0; i < 26; i++) m_used[i] = 1'b0;
        m_wrong = 0;
        phase = 1;
        @(negedge clk);
        gif.restart     = 1'b0;
        gif.guess_valid = 1'b0;
        check("abort_busy", gif.busy, 1'b0);
        check("abort_wrong", gif.wrong_count, 4'd0);
        check("abort_word", gif.out_word, pack("___"));
        check("abort_revealed", gif.revealed, 7'b1111000);
        repeat (10) @(negedge clk);
        do_guess("H", 1'b0);
        check("post_abort_wrong", gif.wrong_count, 4'd1);

        // Asynchronous reset mid-scan
        @(negedge clk);
        gif.guess_valid  = 1'b1;
        gif.guess_letter = "C";
        @(negedge clk);
        gif.guess_valid = 1'b0;
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("areset_word", gif.out_word, pack("_______"));
        check("areset_state", {gif.revealed, gif.wrong_count, gif.busy, gif.win, gif.lose},
              {7'h00, 4'd0, 3'b000});
        @(negedge clk);
        reset = 1'b0;
        phase = 0;
        do_guess("C", 1'b0);

        // Random games
        for (int g = 0; g < 15; g++) begin
            len = $urandom_range(3, 7);
            for (int i = 0; i < 7; i++) rw[i*7 +: 7] = (i < len) ? 7'(7'h41 + $urandom_range(0, 25)) : 7'h20;
            do_restart(rw);
            check("rand_restart_word", gif.out_word, m_out_word());
            for (int k = 0; k < 40 && phase == 1; k++) begin
                r = $urandom_range(0, 9);
                if (r == 0) begin
                    do c = 7'($urandom_range(0, 127)); while (c >= 7'h41 && c <= 7'h5A);
                end else if (r <= 4) begin
                    c = m_word[$urandom_range(0, len - 1)];
                end else begin
                    c = 7'(7'h41 + $urandom_range(0, 25));
                end
                do_guess(c, $urandom_range(0, 3) == 0);
            end
            check("rand_end_wrong", gif.wrong_count, 4'(m_wrong));
            check("rand_end_flags", {gif.win, gif.lose}, {phase == 2, phase == 3});
            do_guess(7'(7'h41 + $urandom_range(0, 25)), 1'b0);
        end

        repeat (12) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
